decode_pipe_reg: RTL and testbench
==================================

# decode_pipe_reg

Fetch→decode pipeline register of the five-stage MIPS core. On each rising clock edge it captures the instruction fields decoded by the fetch stage: opcode, function code, rs, rt, rd, and the 32-bit constant valC. It presents them to the decode stage as registered outputs. It supports a stall (hold) and a bubble (insert NOP), and it exports a valid flag so downstream hazard logic can tell real instructions from bubbles.

## Interface
- No parameters; all field widths are fixed by the MIPS-I encoding.
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- D_stall  in  1  hold: keep current contents this cycle.
- D_bubble  in  1  flush: load a NOP bubble this cycle.
- f_op  in  6  opcode from fetch (instr[31:26]).
- f_func  in  6  function code from fetch (instr[5:0]).
- f_rs  in  5  rs field (instr[25:21]).
- f_rd  in  5  rd field (instr[15:11]).
- f_rt  in  5  rt field (instr[20:16]).
- f_valC  in  32  constant from fetch: extended immediate, jump target or shamt, already formed by fetch.
- D_op  out  6  registered opcode.
- D_func  out  6  registered function code.
- D_rs  out  5  registered rs.
- D_rt  out  5  registered rt.
- D_rd  out  5  registered rd.
- D_valC  out  32  registered constant.
- D_valid  out  1  1 = contents are a fetched instruction; 0 = reset or bubble.
- Port order is fixed: D_op, D_func, D_rs, D_rt, D_rd, D_valC, D_valid, clk, rst_n, D_stall, D_bubble, f_op, f_func, f_rs, f_rd, f_rt, f_valC.
- Connect f_rd and f_rt by name. Their input order (rd before rt) differs from the output order.

## Operation
- One register per output field. All outputs come directly from flops, with no combinational path from any input to any output.
- Each rising edge applies exactly one action, chosen by priority:
  1. rst_n == 0: all fields cleared to 0; D_valid = 0.
  2. D_stall == 1: all fields and D_valid hold their values. The f_* inputs are ignored.
  3. D_bubble == 1: all fields = 0; D_valid = 0.
  4. Otherwise: D_op←f_op, D_func←f_func, D_rs←f_rs, D_rt←f_rt, D_rd←f_rd, D_valC←f_valC; D_valid←1.
- The all-zero encoding (op 0, func 0, rs/rt/rd 0, valC 0) is SLL $0,$0,0, an architectural NOP. Reset and bubble contents are therefore harmless downstream.
- Stall wins over bubble when both are asserted. The held instruction is preserved, and the hazard unit re-issues the bubble later.
- Reset wins over stall: a stalled register still clears when rst_n is low.
- Fields are copied verbatim; no decoding, sign extension or width change happens here.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs immediately after edge N and stay until the next updating edge.
- Reset is synchronous. Asserting rst_n between edges has no effect until the next rising edge.
- After reset deassertion, the first load occurs at the first rising edge with rst_n = 1 and D_stall = 0.
- Stall is level-sensitive per edge. N consecutive stalled edges hold the contents for N extra cycles.
- Input changes between edges, including changes while stalled, never affect the outputs.
- Initial (pre-reset) flop values are undefined in silicon. For simulation, initialize them to 0.

## Test plan
- Reset: hold rst_n=0 with f_op=6'h0D, f_valC=88 for 2 edges → all outputs 0, D_valid=0. Release rst_n → the next edge loads op=001101, valC=88, D_valid=1.
- Normal load: f_op=000000, f_func=100111, f_rs=19, f_rt=30, f_rd=29, f_valC=66, stall=0 → after one edge, op=000000, func=100111, rs=19, rt=30, rd=29, valC=66, valid=1. This also checks that rt and rd are not swapped.
- Stall hold: with the register holding valC=66, assert D_stall and drive func=100100, rs=18, rt=22, rd=21, valC=77 for 2 edges → outputs stay at the valC=66 set. Drop the stall → the next edge loads valC=77, rs=18, rt=22, rd=21.
- Stall over bubble and bubble: D_stall=1 with D_bubble=1 → contents held. Then D_stall=0 with D_bubble=1 → all fields 0, valid=0. Then D_bubble=0 → fields load normally.
- Reset during stall: register holding valC=99, D_stall=1, rst_n=0 for one edge → all outputs 0, valid=0.
- Back-to-back loads: a different f_* set on each of 4 consecutive edges → each set appears exactly one edge later, with no skipped or duplicated values.

Source files
------------

// File: rtl/decode_pipe_reg.sv
// decode_pipe_reg
// Fetch-to-decode pipeline register for the five-stage MIPS core.
// Captures the fetch-stage instruction fields on each rising edge of clk and
// presents them to decode as registered outputs, with stall (hold) and
// bubble (load all-zero NOP) controls plus a valid flag for hazard logic.
//
// Ports
//   D_op, D_func, D_rs, D_rt, D_rd, D_valC  registered instruction fields
//   D_valid    1 = fetched instruction, 0 = reset or bubble
//   clk        system clock, rising-edge active
//   rst_n      synchronous active-low reset
//   D_stall    hold current contents this edge
//   D_bubble   load a NOP bubble this edge
//   f_op, f_func, f_rs, f_rd, f_rt, f_valC  fields from fetch
//
// Priority per edge: reset > stall > bubble > load.
// The all-zero contents encode SLL $0,$0,0, so reset and bubble are harmless.

module decode_pipe_reg (
  output logic [5:0]  D_op,
  output logic [5:0]  D_func,
  output logic [4:0]  D_rs,
  output logic [4:0]  D_rt,
  output logic [4:0]  D_rd,
  output logic [31:0] D_valC,
  output logic        D_valid,
  input  logic        clk,
  input  logic        rst_n,
  input  logic        D_stall,
  input  logic        D_bubble,
  input  logic [5:0]  f_op,
  input  logic [5:0]  f_func,
  input  logic [4:0]  f_rs,
  input  logic [4:0]  f_rd,
  input  logic [4:0]  f_rt,
  input  logic [31:0] f_valC
);

  // Pre-reset values are undefined in silicon; start at zero in simulation.
  logic [5:0]  op_q    = '0;
  logic [5:0]  func_q  = '0;
  logic [4:0]  rs_q    = '0;
  logic [4:0]  rt_q    = '0;
  logic [4:0]  rd_q    = '0;
  logic [31:0] valc_q  = '0;
  logic        valid_q = 1'b0;

  logic [5:0]  op_d;
  logic [5:0]  func_d;
  logic [4:0]  rs_d;
  logic [4:0]  rt_d;
  logic [4:0]  rd_d;
  logic [31:0] valc_d;
  logic        valid_d;

  always_comb begin
    op_d    = op_q;
    func_d  = func_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    valc_d  = valc_q;
    valid_d = valid_q;
    if (D_stall) begin
      // hold: defaults already keep every field
    end else if (D_bubble) begin
      op_d    = '0;
      func_d  = '0;
      rs_d    = '0;
      rt_d    = '0;
      rd_d    = '0;
      valc_d  = '0;
      valid_d = 1'b0;
    end else begin
      op_d    = f_op;
      func_d  = f_func;
      rs_d    = f_rs;
      rt_d    = f_rt;
      rd_d    = f_rd;
      valc_d  = f_valC;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q    <= '0;
      func_q  <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      valc_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      op_q    <= op_d;
      func_q  <= func_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      valc_q  <= valc_d;
      valid_q <= valid_d;
    end
  end

  assign D_op    = op_q;
  assign D_func  = func_q;
  assign D_rs    = rs_q;
  assign D_rt    = rt_q;
  assign D_rd    = rd_q;
  assign D_valC  = valc_q;
  assign D_valid = valid_q;

endmodule

// File: tb/tb_decode_pipe_reg.sv
module tb_decode_pipe_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        D_stall;
  logic        D_bubble;
  logic [5:0]  f_op;
  logic [5:0]  f_func;
  logic [4:0]  f_rs;
  logic [4:0]  f_rd;
  logic [4:0]  f_rt;
  logic [31:0] f_valC;
  logic [5:0]  D_op;
  logic [5:0]  D_func;
  logic [4:0]  D_rs;
  logic [4:0]  D_rt;
  logic [4:0]  D_rd;
  logic [31:0] D_valC;
  logic        D_valid;

  int n_cmp = 0;
  int n_bad = 0;

  decode_pipe_reg dut (
    .D_op(D_op), .D_func(D_func), .D_rs(D_rs), .D_rt(D_rt), .D_rd(D_rd),
    .D_valC(D_valC), .D_valid(D_valid),
    .clk(clk), .rst_n(rst_n), .D_stall(D_stall), .D_bubble(D_bubble),
    .f_op(f_op), .f_func(f_func), .f_rs(f_rs), .f_rd(f_rd), .f_rt(f_rt),
    .f_valC(f_valC)
  );

  always #5 clk = ~clk;

  // Observed bundle: op|func|rs|rt|rd|valC|valid (60 bits)
  logic [59:0] obs;
  assign obs = {D_op, D_func, D_rs, D_rt, D_rd, D_valC, D_valid};

  function automatic logic [59:0] pack(input logic [5:0] op, input logic [5:0] fn,
                                       input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [31:0] vc,
                                       input logic v);
    return {op, fn, rs, rt, rd, vc, v};
  endfunction

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] vc);
    f_op = op; f_func = fn; f_rs = rs; f_rt = rt; f_rd = rd; f_valC = vc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [59:0] exp;
    rst_n = 1'b0; D_stall = 1'b0; D_bubble = 1'b0;
    drive(6'h0D, 6'h00, 5'd0, 5'd0, 5'd0, 32'd88);
    for (int i = 0; i < 2; i++) begin
      step();
      exp = '0;
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL reset_hold_%0d: got %h expected %h", i, obs, exp);
      end
    end
    rst_n = 1'b1;
    step();
    exp = pack(6'h0D, 6'h00, 5'd0, 5'd0, 5'd0, 32'd88, 1'b1);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL reset_release_load: got %h expected %h", obs, exp);
    end
    // reset pulsed between edges must not touch the outputs
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL reset_midcycle_async: got %h expected %h", obs, exp);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_normal_load();
    logic [59:0] exp;
    drive(6'b000000, 6'b100111, 5'd19, 5'd30, 5'd29, 32'd66);
    step();
    exp = pack(6'b000000, 6'b100111, 5'd19, 5'd30, 5'd29, 32'd66, 1'b1);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL normal_load: got %h expected %h", obs, exp);
    end
    n_cmp++;
    if (D_rt !== 5'd30 || D_rd !== 5'd29) begin
      n_bad++;
      $display("FAIL rt_rd_order: got rt=%0d rd=%0d expected rt=30 rd=29", D_rt, D_rd);
    end
  endtask

  task automatic test_stall();
    logic [59:0] held, exp;
    held = pack(6'b000000, 6'b100111, 5'd19, 5'd30, 5'd29, 32'd66, 1'b1);
    D_stall = 1'b1;
    drive(6'b000000, 6'b100100, 5'd18, 5'd22, 5'd21, 32'd77);
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (obs !== held) begin
        n_bad++;
        $display("FAIL stall_hold_%0d: got %h expected %h", i, obs, held);
      end
    end
    // input changes while stalled must not leak through
    drive(6'h3F, 6'h3F, 5'd31, 5'd31, 5'd31, 32'hFFFF_FFFF);
    #3;
    n_cmp++;
    if (obs !== held) begin
      n_bad++;
      $display("FAIL stall_input_change: got %h expected %h", obs, held);
    end
    drive(6'b000000, 6'b100100, 5'd18, 5'd22, 5'd21, 32'd77);
    D_stall = 1'b0;
    step();
    exp = pack(6'b000000, 6'b100100, 5'd18, 5'd22, 5'd21, 32'd77, 1'b1);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL stall_release_load: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_bubble();
    logic [59:0] held, exp;
    held = pack(6'b000000, 6'b100100, 5'd18, 5'd22, 5'd21, 32'd77, 1'b1);
    drive(6'h23, 6'h00, 5'd4, 5'd5, 5'd0, 32'd12);
    D_stall = 1'b1; D_bubble = 1'b1;
    step();
    n_cmp++;
    if (obs !== held) begin
      n_bad++;
      $display("FAIL stall_over_bubble: got %h expected %h", obs, held);
    end
    D_stall = 1'b0;
    step();
    exp = '0;
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL bubble_nop: got %h expected %h", obs, exp);
    end
    D_bubble = 1'b0;
    step();
    exp = pack(6'h23, 6'h00, 5'd4, 5'd5, 5'd0, 32'd12, 1'b1);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL bubble_release_load: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_reset_during_stall();
    logic [59:0] exp;
    drive(6'h08, 6'h00, 5'd1, 5'd2, 5'd0, 32'd99);
    step();
    exp = pack(6'h08, 6'h00, 5'd1, 5'd2, 5'd0, 32'd99, 1'b1);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL rds_preload: got %h expected %h", obs, exp);
    end
    D_stall = 1'b1; rst_n = 1'b0;
    step();
    exp = '0;
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL reset_over_stall: got %h expected %h", obs, exp);
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL stall_after_reset: got %h expected %h", obs, exp);
    end
    D_stall = 1'b0;
    step();
    exp = pack(6'h08, 6'h00, 5'd1, 5'd2, 5'd0, 32'd99, 1'b1);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL first_load_after_stall: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  ops   [4] = '{6'h01, 6'h0F, 6'h2B, 6'h00};
    logic [5:0]  fns   [4] = '{6'h11, 6'h22, 6'h05, 6'h2A};
    logic [4:0]  rss   [4] = '{5'd3, 5'd7, 5'd11, 5'd31};
    logic [4:0]  rts   [4] = '{5'd4, 5'd8, 5'd12, 5'd1};
    logic [4:0]  rds   [4] = '{5'd5, 5'd9, 5'd13, 5'd2};
    logic [31:0] vcs   [4] = '{32'h0000_1234, 32'hFFFF_8000, 32'hA5A5_5A5A, 32'd1};
    logic [59:0] exp;
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], fns[i], rss[i], rts[i], rds[i], vcs[i]);
      step();
      exp = pack(ops[i], fns[i], rss[i], rts[i], rds[i], vcs[i], 1'b1);
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL back_to_back_%0d: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; D_stall = 1'b0; D_bubble = 1'b0;
    drive(6'h0, 6'h0, 5'd0, 5'd0, 5'd0, 32'd0);
    test_reset();
    test_normal_load();
    test_stall();
    test_bubble();
    test_reset_during_stall();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
